// File: rtl/binary_mul_pkg.sv
// Shared types and width helpers for the iterative binary multiplier.
package binary_mul_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } mul_state_t;

    localparam int MIN_W = 2;
    localparam int MAX_W = 32;

    // Counter holds W-1 down to 0.
    function automatic int cnt_width(int w);
        return (w > 1) ? $clog2(w) : 1;
    endfunction

    // One spare bit above the product keeps the carry / sign of the upper half.
    function automatic int acc_width(int w);
        return 2 * w + 1;
    endfunction

endpackage

// File: rtl/binary_mul_step.sv
// One radix-2 iteration: add/sub into the upper half, then shift right by one.
// BINARY_MUL_SIGNED_EN selects Booth (signed) recoding; otherwise unsigned shift-add.
module binary_mul_step #(
    parameter int W = 8
) (
    input  logic [2*W:0] acc,
    input  logic [W-1:0] a,
    input  logic         bit_cur,
`ifdef BINARY_MUL_SIGNED_EN
    input  logic         bit_prev,
`endif
    output logic [2*W:0] acc_next
);

    logic [W:0]     upper;
    logic [W:0]     sum;
    logic [2*W+1:0] wide;

    assign upper = acc[2*W:W];

`ifdef BINARY_MUL_SIGNED_EN
    logic [W:0] a_ext;
    assign a_ext = {a[W-1], a};

    always_comb begin
        sum = upper;
        case ({bit_cur, bit_prev})
            2'b01:   sum = upper + a_ext;
            2'b10:   sum = upper - a_ext;
            default: sum = upper;
        endcase
    end

    // Duplicating the sign bit before the shift makes it arithmetic.
    assign wide = {sum[W], sum, acc[W-1:0]};
`else
    always_comb begin
        sum = upper;
        if (bit_cur) begin
            sum = upper + {1'b0, a};
        end
    end

    assign wide = {1'b0, sum, acc[W-1:0]};
`endif

    assign acc_next = (2*W+1)'(wide >> 1);

endmodule

// File: rtl/binary_mul_seq.sv
// Iterative W x W multiplier with start/busy/done handshake and clock enable.
// BINARY_MUL_SIGNED_EN selects two's complement operands (Booth); default is unsigned.
module binary_mul_seq
    import binary_mul_pkg::*;
#(
    parameter int W = 8
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           en,
    input  logic           start,
    input  logic [W-1:0]   a,
    input  logic [W-1:0]   b,
    output logic           busy,
    output logic           done,
    output logic [2*W-1:0] p,
    output mul_state_t     state
);

    localparam int CW = cnt_width(W);
    localparam int AW = acc_width(W);

    logic [W-1:0]  a_reg;
    logic [W-1:0]  b_reg;
    logic [CW-1:0] cnt;
    logic [CW-1:0] idx;
    logic [AW-1:0] acc;
    logic [AW-1:0] acc_next;

    // Counter runs down, so the multiplier bit under examination is W-1-cnt.
    assign idx = CW'(W - 1) - cnt;

`ifdef BINARY_MUL_SIGNED_EN
    logic bit_prev;
    assign bit_prev = (idx == '0) ? 1'b0 : b_reg[idx - CW'(1)];
`endif

    binary_mul_step #(.W(W)) u_step (
        .acc      (acc),
        .a        (a_reg),
        .bit_cur  (b_reg[idx]),
`ifdef BINARY_MUL_SIGNED_EN
        .bit_prev (bit_prev),
`endif
        .acc_next (acc_next)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
            p     <= '0;
            cnt   <= '0;
            a_reg <= '0;
            b_reg <= '0;
            acc   <= '0;
        end else if (en) begin
            case (state)
                IDLE, DONE: begin
                    done <= 1'b0;
                    if (start) begin
                        state <= RUN;
                        busy  <= 1'b1;
                        a_reg <= a;
                        b_reg <= b;
                        acc   <= '0;
                        cnt   <= CW'(W - 1);
                    end else begin
                        state <= IDLE;
                    end
                end
                RUN: begin
                    acc <= acc_next;
                    if (cnt == '0) begin
                        p     <= acc_next[2*W-1:0];
                        state <= DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end else begin
                        cnt <= cnt - CW'(1);
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_binary_mul_seq.sv
// Bench for binary_mul_seq at W=4 and W=16 against an arithmetic product model.
// Follows the BINARY_MUL_SIGNED_EN build for operand interpretation.
module tb_binary_mul_seq;
    import binary_mul_pkg::*;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic        en, start;
    logic [3:0]  a, b;
    logic        busy, done;
    logic [7:0]  p;
    mul_state_t  state;

    logic        en16, start16;
    logic [15:0] a16, b16;
    logic        busy16, done16;
    logic [31:0] p16;
    mul_state_t  state16;

    int total = 0;
    int bad = 0;

    binary_mul_seq #(.W(4)) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .start(start), .a(a), .b(b),
        .busy(busy), .done(done), .p(p), .state(state)
    );

    binary_mul_seq #(.W(16)) dut16 (
        .clk(clk), .rst_n(rst_n), .en(en16), .start(start16), .a(a16), .b(b16),
        .busy(busy16), .done(done16), .p(p16), .state(state16)
    );

    // ---------------- reference model ----------------
    function automatic longint ref_prod(int w, longint av, longint bv);
        longint x;
        longint y;
        x = av;
        y = bv;
`ifdef BINARY_MUL_SIGNED_EN
        if (x >= (longint'(1) << (w - 1))) x = x - (longint'(1) << w);
        if (y >= (longint'(1) << (w - 1))) y = y - (longint'(1) << w);
`endif
        return (x * y) & ((longint'(1) << (2 * w)) - 1);
    endfunction

    // ---------------- drivers (called at a negedge, return at a negedge) ----------------
    task automatic drive_op4(input logic [3:0] av, input logic [3:0] bv,
                             input int stall_at, input int stall_len,
                             output int lat, output int busy_cyc, output logic [7:0] res);
        a = av;
        b = bv;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        a = 4'($urandom);
        b = 4'($urandom);
        lat = 0;
        busy_cyc = 0;
        while (!done && lat < 100) begin
            en = (lat >= stall_at && lat < stall_at + stall_len) ? 1'b0 : 1'b1;
            if (busy) busy_cyc++;
            @(negedge clk);
            lat++;
        end
        en = 1'b1;
        res = p;
    endtask

    task automatic drive_op16(input logic [15:0] av, input logic [15:0] bv,
                              output int lat, output logic [31:0] res);
        a16 = av;
        b16 = bv;
        start16 = 1'b1;
        @(negedge clk);
        start16 = 1'b0;
        a16 = 16'($urandom);
        b16 = 16'($urandom);
        lat = 0;
        while (!done16 && lat < 200) begin
            @(negedge clk);
            lat++;
        end
        res = p16;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        #12;
        total++;
        if (busy !== 1'b0 || done !== 1'b0 || p !== 8'h00 || state !== IDLE) begin
            bad++;
            $display("FAIL reset_state: busy=%b done=%b p=%h state=%0d, want 0 0 00 IDLE",
                     busy, done, p, state);
        end
        total++;
        if (busy16 !== 1'b0 || done16 !== 1'b0 || p16 !== 32'h0) begin
            bad++;
            $display("FAIL reset_state16: busy=%b done=%b p=%h, want 0 0 0", busy16, done16, p16);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        total++;
        if (busy !== 1'b0 || done !== 1'b0 || p !== 8'h00) begin
            bad++;
            $display("FAIL idle_hold: busy=%b done=%b p=%h, want 0 0 00", busy, done, p);
        end
    endtask

    task automatic test_exhaustive();
        int lat, bc;
        logic [7:0] res;
        logic [7:0] exp;
        for (int i = 0; i < 16; i++) begin
            for (int j = 0; j < 16; j++) begin
                drive_op4(4'(i), 4'(j), 1000, 0, lat, bc, res);
                exp = 8'(ref_prod(4, longint'(i), longint'(j)));
                total++;
                if (res !== exp) begin
                    bad++;
                    $display("FAIL exh_product a=%0d b=%0d: got %h want %h", i, j, res, exp);
                end
                total++;
                if (lat != 4 || bc != 4) begin
                    bad++;
                    $display("FAIL exh_latency a=%0d b=%0d: lat=%0d busy=%0d want 4 4", i, j, lat, bc);
                end
            end
        end
    endtask

    task automatic test_spot();
        int lat, bc;
        logic [7:0] res;
        logic [3:0] sa [3];
        logic [3:0] sb [3];
        logic [7:0] se [3];
`ifdef BINARY_MUL_SIGNED_EN
        sa = '{4'h8, 4'h7, 4'hF};
        sb = '{4'h8, 4'h8, 4'hF};
        se = '{8'h40, 8'hC8, 8'h01};
`else
        sa = '{4'hF, 4'h0, 4'h7};
        sb = '{4'hF, 4'hF, 4'h8};
        se = '{8'hE1, 8'h00, 8'h38};
`endif
        for (int k = 0; k < 3; k++) begin
            drive_op4(sa[k], sb[k], 1000, 0, lat, bc, res);
            total++;
            if (res !== se[k]) begin
                bad++;
                $display("FAIL spot a=%h b=%h: got %h want %h", sa[k], sb[k], res, se[k]);
            end
        end
    endtask

    task automatic test_handshake();
        int busy_cnt = 0;
        int done_cnt = 0;
        int first_done = -1;
        logic [7:0] got = 8'h00;
        logic [7:0] exp;
        exp = 8'(ref_prod(4, 3, 11));
        @(negedge clk);
        a = 4'd3;
        b = 4'hB;
        start = 1'b1;
        @(negedge clk);
        for (int n = 0; n < 8; n++) begin
            start = (n == 1 || n == 2);
            if (start) begin
                a = 4'($urandom);
                b = 4'($urandom);
            end
            if (busy) busy_cnt++;
            if (done) begin
                done_cnt++;
                got = p;
                if (first_done < 0) first_done = n;
            end
            @(negedge clk);
        end
        start = 1'b0;
        total++;
        if (busy_cnt != 4) begin
            bad++;
            $display("FAIL hs_busy_cycles: got %0d want 4", busy_cnt);
        end
        total++;
        if (done_cnt != 1 || first_done != 4) begin
            bad++;
            $display("FAIL hs_done_pulse: count=%0d at=%0d want 1 at 4", done_cnt, first_done);
        end
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL hs_product: got %h want %h", got, exp);
        end
    endtask

    task automatic test_stall();
        int lat, bc;
        logic [7:0] res;
        logic [7:0] exp;
        exp = 8'(ref_prod(4, 9, 6));
        drive_op4(4'h9, 4'h6, 1, 3, lat, bc, res);
        total++;
        if (lat != 7) begin
            bad++;
            $display("FAIL stall_latency: got %0d want 7", lat);
        end
        total++;
        if (res !== exp) begin
            bad++;
            $display("FAIL stall_product: got %h want %h", res, exp);
        end
        en = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            total++;
            if (done !== 1'b1 || p !== exp) begin
                bad++;
                $display("FAIL stall_done_hold %0d: done=%b p=%h want 1 %h", k, done, p, exp);
            end
        end
        en = 1'b1;
        @(negedge clk);
        total++;
        if (done !== 1'b0 || p !== exp) begin
            bad++;
            $display("FAIL stall_done_clear: done=%b p=%h want 0 %h", done, p, exp);
        end
    endtask

    task automatic test_reset_mid();
        int lat, bc;
        logic [7:0] res;
        a = 4'd7;
        b = 4'd3;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        total++;
        if (busy !== 1'b0 || done !== 1'b0 || p !== 8'h00 || state !== IDLE) begin
            bad++;
            $display("FAIL reset_mid: busy=%b done=%b p=%h state=%0d want 0 0 00 IDLE",
                     busy, done, p, state);
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int n = 0; n < 6; n++) begin
            @(negedge clk);
            total++;
            if (done !== 1'b0) begin
                bad++;
                $display("FAIL reset_no_done: done=%b at %0d want 0", done, n);
            end
        end
        drive_op4(4'd5, 4'd5, 1000, 0, lat, bc, res);
        total++;
        if (res !== 8'd25 || lat != 4) begin
            bad++;
            $display("FAIL reset_restart: p=%h lat=%0d want 19 4", res, lat);
        end
    endtask

    task automatic test_w16();
        int lat;
        logic [31:0] res;
        logic [31:0] exp;
        logic [15:0] ca [3];
        logic [15:0] cb [3];
        logic [15:0] ra, rb;
        ca = '{16'h8000, 16'h8000, 16'hFFFF};
        cb = '{16'h8000, 16'h7FFF, 16'hFFFF};
        for (int k = 0; k < 1003; k++) begin
            if (k < 3) begin
                ra = ca[k];
                rb = cb[k];
            end else begin
                ra = 16'($urandom);
                rb = 16'($urandom_range(0, 65535));
            end
            drive_op16(ra, rb, lat, res);
            exp = 32'(ref_prod(16, longint'(ra), longint'(rb)));
            total++;
            if (res !== exp || lat != 16) begin
                bad++;
                $display("FAIL w16 a=%h b=%h: p=%h lat=%0d want %h 16", ra, rb, res, lat, exp);
            end
        end
    endtask

    initial begin
        en = 1'b1;
        start = 1'b0;
        a = '0;
        b = '0;
        en16 = 1'b1;
        start16 = 1'b0;
        a16 = '0;
        b16 = '0;
        test_reset();
        test_exhaustive();
        test_spot();
        test_handshake();
        test_stall();
        test_reset_mid();
        test_w16();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
